// File: rtl/pe_array_ctrl.sv
//------------------------------------------------------------------------------
// Module  : pe_array_ctrl
// Purpose : Run sequencer for the linear PE array (load, compute wait, drain).
//           Define PE_CTRL_PERF_EN to add the perf_cycles run-length counter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pe_array_ctrl #(
  parameter int  PE_NUM       = 8,
  parameter int  LOAD_NUM     = 2048,
  parameter int  COMP_CYCLES  = 1024,
  parameter int  DRAIN_CYCLES = 8,
  parameter int  DATA_W       = 32,
  localparam int PS_W         = $clog2(PE_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              arr_din_v,
  output logic [DATA_W-1:0] arr_din,
  output logic              arr_load,
  output logic              m_valid,
  output logic [PS_W-1:0]   pe_sel,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef PE_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int c_wc_w = (LOAD_NUM > 1) ? $clog2(LOAD_NUM) : 1;
  localparam int c_cc_w = (COMP_CYCLES > 1) ? $clog2(COMP_CYCLES) : 1;
  localparam int c_dc_w = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [c_wc_w-1:0] c_wc_last = c_wc_w'(LOAD_NUM - 1);
  localparam logic [PS_W-1:0]   c_pe_last = PS_W'(PE_NUM - 1);
  localparam logic [c_cc_w-1:0] c_cc_last = c_cc_w'(COMP_CYCLES - 1);
  localparam logic [c_dc_w-1:0] c_dc_last = c_dc_w'(DRAIN_CYCLES - 1);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_load  = 3'd1;
  localparam logic [2:0] c_st_comp  = 3'd2;
  localparam logic [2:0] c_st_drain = 3'd3;
  localparam logic [2:0] c_st_done  = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [c_wc_w-1:0] r_word_cnt;
  logic [PS_W-1:0]   r_pe_sel;
  logic [c_cc_w-1:0] r_comp_cnt;
  logic [c_dc_w-1:0] r_drain_cnt;
  logic              r_din_v;
  logic [DATA_W-1:0] r_din;
  logic              r_m_valid;
  logic              r_err;

  logic w_in_load;
  logic w_beat;
  logic w_started;
  logic w_last_beat;
  logic w_gap;
  logic w_accept_start;

  assign w_in_load      = (r_state == c_st_load);
  assign w_beat         = w_in_load & s_valid;
  // Any nonzero position means at least one beat has already gone to the array.
  assign w_started      = (r_word_cnt != '0) || (r_pe_sel != '0);
  assign w_last_beat    = w_beat && (r_word_cnt == c_wc_last) && (r_pe_sel == c_pe_last);
  assign w_gap          = w_in_load && !s_valid && w_started;
  assign w_accept_start = (r_state == c_st_idle) && start && !abort;

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle:  if (start) w_next = c_st_load;
      c_st_load: begin
        if (w_gap)            w_next = c_st_idle;
        else if (w_last_beat) w_next = c_st_comp;
      end
      c_st_comp:  if (r_comp_cnt == c_cc_last)  w_next = c_st_drain;
      c_st_drain: if (r_drain_cnt == c_dc_last) w_next = c_st_done;
      c_st_done:  w_next = c_st_idle;
      default:    w_next = c_st_idle;
    endcase
    if (abort) w_next = c_st_idle;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_st_idle;
      r_word_cnt  <= '0;
      r_pe_sel    <= '0;
      r_comp_cnt  <= '0;
      r_drain_cnt <= '0;
      r_din_v     <= 1'b0;
      r_din       <= '0;
      r_m_valid   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_din_v   <= w_beat & ~abort;
      r_din     <= (w_beat && !abort) ? s_data : '0;
      r_m_valid <= arr_load & ~abort;

      if (abort || w_gap || w_last_beat) begin
        r_word_cnt <= '0;
        r_pe_sel   <= '0;
      end else if (w_beat) begin
        if (r_word_cnt == c_wc_last) begin
          r_word_cnt <= '0;
          r_pe_sel   <= r_pe_sel + 1'b1;
        end else begin
          r_word_cnt <= r_word_cnt + 1'b1;
        end
      end

      if ((r_state == c_st_comp) && !abort && (r_comp_cnt != c_cc_last))
        r_comp_cnt <= r_comp_cnt + 1'b1;
      else
        r_comp_cnt <= '0;

      if ((r_state == c_st_drain) && !abort && (r_drain_cnt != c_dc_last))
        r_drain_cnt <= r_drain_cnt + 1'b1;
      else
        r_drain_cnt <= '0;

      if (w_accept_start)
        r_err <= 1'b0;
      else if (w_gap && !abort)
        r_err <= 1'b1;
    end
  end

  assign s_ready   = w_in_load;
  assign busy      = (r_state != c_st_idle);
  assign done      = (r_state == c_st_done);
  assign arr_load  = (r_state == c_st_drain);
  assign arr_din_v = r_din_v;
  assign arr_din   = r_din;
  assign m_valid   = r_m_valid;
  assign pe_sel    = r_pe_sel;
  assign err       = r_err;

`ifdef PE_CTRL_PERF_EN
  logic [31:0] r_perf;

  // Stops by itself once the run returns to IDLE; an abort cycle is not counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_perf <= '0;
    else if (w_accept_start)
      r_perf <= '0;
    else if (busy && !abort)
      r_perf <= r_perf + 32'd1;
  end

  assign perf_cycles = r_perf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pe_array_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_pe_array_ctrl
// Purpose : Self-checking bench for pe_array_ctrl (PE_NUM=2, LOAD_NUM=4,
//           COMP_CYCLES=5, DRAIN_CYCLES=2) against a run-timeline model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pe_array_ctrl;

  localparam int PE_NUM = 2;
  localparam int LOAD_NUM = 4;
  localparam int COMP = 5;
  localparam int DRAIN = 2;
  localparam int DW = 32;
  localparam int TOTAL = PE_NUM * LOAD_NUM;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, arr_din_v, arr_load, m_valid, busy, done, err;
  logic [DW-1:0] arr_din;
  logic [0:0]    pe_sel;
`ifdef PE_CTRL_PERF_EN
  logic [31:0]   perf_cycles;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_beat = 0;
  int q_din[$];
  int q_pe[$];
  int q_load[$];
  int q_mv[$];
  int q_done[$];

  pe_array_ctrl #(
    .PE_NUM(PE_NUM), .LOAD_NUM(LOAD_NUM), .COMP_CYCLES(COMP),
    .DRAIN_CYCLES(DRAIN), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .arr_din_v(arr_din_v), .arr_din(arr_din), .arr_load(arr_load),
    .m_valid(m_valid), .pe_sel(pe_sel), .busy(busy), .done(done), .err(err)
`ifdef PE_CTRL_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 loading, 2 scheduled; after the last beat (cycle
  // tlast) every output is a fixed function of the distance from tlast.
  typedef struct {
    int          mode;
    int          nbeats;
    int          tlast;
    int          n;
    logic        err;
    int          perf;
    logic        din_v;
    logic [31:0] din;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_step(input mstate_t c, input logic st, input logic ab,
                                         input logic sv, input logic [31:0] sd);
    mstate_t x = c;
    x.n = c.n + 1;
    x.din_v = 1'b0;
    x.din = '0;
    if (c.mode != 0 && !ab) x.perf = c.perf + 1;
    if (ab) begin
      x.mode = 0;
    end else if (c.mode == 0) begin
      if (st) begin
        x.mode = 1; x.nbeats = 0; x.err = 1'b0; x.perf = 0;
      end
    end else if (c.mode == 1) begin
      if (sv) begin
        x.din_v = 1'b1;
        x.din = sd;
        x.nbeats = c.nbeats + 1;
        if (x.nbeats == TOTAL) begin
          x.mode = 2; x.tlast = c.n;
        end
      end else if (c.nbeats > 0) begin
        x.err = 1'b1; x.mode = 0;
      end
    end else if (x.n - x.tlast > COMP + DRAIN + 1) begin
      x.mode = 0;
    end
    return x;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst)
      m <= '{mode:0, nbeats:0, tlast:0, n:0, err:1'b0, perf:0, din_v:1'b0, din:32'd0};
    else
      m <= model_step(m, start, abort, s_valid, s_data);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int d;
    d = m.n - m.tlast;
    chk("s_ready", 32'(s_ready), 32'(m.mode == 1));
    chk("busy", 32'(busy), 32'(m.mode != 0));
    chk("arr_din_v", 32'(arr_din_v), 32'(m.din_v));
    chk("arr_din", arr_din, m.din);
    chk("pe_sel", 32'(pe_sel), (m.mode == 1) ? 32'(m.nbeats / LOAD_NUM) : 32'd0);
    chk("arr_load", 32'(arr_load), 32'(m.mode == 2 && d >= COMP + 1 && d <= COMP + DRAIN));
    chk("m_valid", 32'(m_valid), 32'(m.mode == 2 && d >= COMP + 2 && d <= COMP + DRAIN + 1));
    chk("done", 32'(done), 32'(m.mode == 2 && d == COMP + DRAIN + 1));
    chk("err", 32'(err), 32'(m.err));
`ifdef PE_CTRL_PERF_EN
    chk("perf_cycles", perf_cycles, 32'(m.perf));
`endif
  end

  always @(negedge clk) begin
    if (arr_din_v) q_din.push_back(int'(arr_din));
    if (s_valid && s_ready) begin
      q_pe.push_back(int'(pe_sel));
      last_beat = cyc;
    end
    if (arr_load) q_load.push_back(cyc);
    if (m_valid) q_mv.push_back(cyc);
    if (done) q_done.push_back(cyc);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    q_din.delete(); q_pe.delete(); q_load.delete(); q_mv.delete(); q_done.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_beats(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data = 32'(base + i);
      step();
    end
    s_valid = 1'b0;
    s_data = '0;
  endtask

  task automatic check_nominal(input string tag);
    chk({tag, "_din_count"}, 32'(q_din.size()), 32'd8);
    for (int i = 0; i < q_din.size() && i < 8; i++)
      chk({tag, "_din_val"}, 32'(q_din[i]), 32'(i + 1));
    chk({tag, "_beat_count"}, 32'(q_pe.size()), 32'd8);
    for (int i = 0; i < q_pe.size() && i < 8; i++)
      chk({tag, "_pe_sel_beat"}, 32'(q_pe[i]), (i < 4) ? 32'd0 : 32'd1);
    chk({tag, "_load_count"}, 32'(q_load.size()), 32'd2);
    if (q_load.size() == 2) begin
      chk({tag, "_load_first"}, 32'(q_load[0]), 32'(last_beat + 6));
      chk({tag, "_load_last"}, 32'(q_load[1]), 32'(last_beat + 7));
    end
    chk({tag, "_mv_count"}, 32'(q_mv.size()), 32'd2);
    if (q_mv.size() == 2) begin
      chk({tag, "_mv_first"}, 32'(q_mv[0]), 32'(last_beat + 7));
      chk({tag, "_mv_last"}, 32'(q_mv[1]), 32'(last_beat + 8));
    end
    chk({tag, "_done_count"}, 32'(q_done.size()), 32'd1);
    if (q_done.size() == 1)
      chk({tag, "_done_cycle"}, 32'(q_done[0]), 32'(last_beat + 8));
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_pe_sel", 32'(pe_sel), 32'd0);
    chk("rst_arr_din", arr_din, 32'd0);
    step();

    // Nominal run
    clear_logs();
    do_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_s_ready", 32'(s_ready), 32'd1);
    send_beats(8, 1);
    repeat (12) step();
    check_nominal("nominal");

    // Late stream: waiting before the first beat is legal
    clear_logs();
    do_start();
    repeat (3) step();
    send_beats(8, 1);
    repeat (12) step();
    check_nominal("late");

    // Gap after three beats
    clear_logs();
    do_start();
    send_beats(3, 1);
    step();
    chk("gap_err", 32'(err), 32'd1);
    chk("gap_busy", 32'(busy), 32'd0);
    repeat (15) step();
    chk("gap_no_load", 32'(q_load.size()), 32'd0);
    chk("gap_no_done", 32'(q_done.size()), 32'd0);
    chk("gap_err_sticky", 32'(err), 32'd1);
    do_start();
    chk("restart_clears_err", 32'(err), 32'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_load_busy", 32'(busy), 32'd0);
    step();

    // Abort in COMPUTE at comp_cnt == 2
    clear_logs();
    do_start();
    send_beats(8, 1);
    repeat (2) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_comp_busy", 32'(busy), 32'd0);
    repeat (10) step();
    chk("abort_no_load", 32'(q_load.size()), 32'd0);
    chk("abort_no_mv", 32'(q_mv.size()), 32'd0);
    chk("abort_no_done", 32'(q_done.size()), 32'd0);

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    chk("start_abort_s_ready", 32'(s_ready), 32'd0);
    step();
    chk("start_abort_stay_idle", 32'(busy), 32'd0);

    // Asynchronous reset in DRAIN
    clear_logs();
    do_start();
    send_beats(8, 1);
    repeat (6) step();
    chk("pre_rst_arr_load", 32'(arr_load), 32'd1);
    chk("pre_rst_m_valid", 32'(m_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_arr_load", 32'(arr_load), 32'd0);
    chk("async_rst_m_valid", 32'(m_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    repeat (2) step();
    rst = 1'b1;
    step();
    clear_logs();
    do_start();
    send_beats(8, 1);
    repeat (12) step();
    check_nominal("post_rst");

`ifdef PE_CTRL_PERF_EN
    // 1 wait + 8 load + 5 compute + 2 drain + 1 done busy cycles
    do_start();
    step();
    send_beats(8, 1);
    repeat (12) step();
    chk("perf_nominal", perf_cycles, 32'd17);
    do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("perf_start_ignored", perf_cycles, 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    chk("perf_abort_hold", perf_cycles, 32'd1);
`endif

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pe_array_ctrl.md
# pe_array_ctrl

Run sequencer for the linear PE array. It accepts a start command and a valid/ready input stream. It then drives the array's contiguous load stream (PE_NUM × LOAD_NUM words), waits a fixed compute window, and pulses the array's output-capture `load` for the drain window. Sits between the host/DMA stream and the PE array; the array's output register supplies the data, and this block supplies only the qualifying valid.

## Interface
- PE_NUM, 8, number of PEs in the array (≥2)
- LOAD_NUM, 2048, words loaded per PE
- COMP_CYCLES, 1024, cycles from end of load to first capture (≥1)
- DRAIN_CYCLES, 8, cycles `arr_load` is held high (≥1)
- DATA_W, 32, stream word width (2×DATA_WIDTH)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle run request; honoured only in IDLE
- abort  in  1  synchronous abort; any state → IDLE
- s_valid  in  1  upstream word valid
- s_data  in  DATA_W  upstream word
- s_ready  out  1  high exactly while state = LOAD
- arr_din_v  out  1  to array `din_overlay_v`
- arr_din  out  DATA_W  to array `din_overlay`
- arr_load  out  1  to array `load`
- m_valid  out  1  qualifies array `dout_overlay`
- pe_sel  out  $clog2(PE_NUM)  index of PE currently being loaded
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at run completion
- err  out  1  sticky; stream gap during LOAD
- perf_cycles  out  32  present only with PE_CTRL_PERF_EN

## Operation
- States: IDLE, LOAD, COMPUTE, DRAIN, DONE.
- IDLE: on `start` (and not `abort`), go to LOAD and clear `err`. `start` in any other state is ignored.
- LOAD:
  - Each beat with `s_valid & s_ready` is registered onto `arr_din_v=1` and `arr_din=s_data`.
  - `word_cnt` counts 0..LOAD_NUM-1 and then wraps to 0, incrementing `pe_sel`.
  - After beat number PE_NUM×LOAD_NUM, go to COMPUTE.
- Gap rule: the array's own counter resets on any valid gap, so `s_valid=0` in any LOAD cycle after the first accepted beat sets `err=1` and goes to IDLE. Beats are not replayed. Before the first beat, waiting is allowed.
- COMPUTE: `comp_cnt` runs 0..COMP_CYCLES-1, then the block goes to DRAIN. `arr_din_v=0` and `arr_din=0` throughout.
- DRAIN: `arr_load=1` for DRAIN_CYCLES cycles, then go to DONE.
- DONE: `done=1` for one cycle, then go to IDLE.
- abort: from any state, the next state is IDLE. All counters, `arr_*`, and `m_valid` are zero on the next cycle. `err` is unchanged. If `abort` and `start` occur in the same cycle, `abort` wins.
- Counters are sized with $clog2 of their terminal value plus 1. No wrap is possible except `word_cnt`, which wraps by design.

## Timing
- Reset values: state IDLE. `s_ready`, `arr_din_v`, `arr_load`, `m_valid`, `busy`, `done`, `err` = 0. `arr_din`=0, `pe_sel`=0, `perf_cycles`=0.
- `start` at cycle t gives `busy=1` and `s_ready=1` at t+1.
- Accepted beat at cycle t gives `arr_din_v`/`arr_din` at t+1.
- The last accepted beat at t gives `s_ready=0` at t+1 and COMPUTE at t+1.
- `arr_load` first goes high at t+1+COMP_CYCLES.
- `m_valid` is `arr_load` delayed by one cycle, matching the array's output register. It is high for exactly DRAIN_CYCLES cycles.
- `done` is high in the cycle after the last `arr_load` cycle, which coincides with the last `m_valid`. `busy` falls one cycle later.
- No backpressure on the output side: the downstream consumer must accept every `m_valid` beat.
- Asynchronous reset mid-run: all outputs go to their reset values immediately, with no `done` pulse.

## Configuration
- PE_CTRL_PERF_EN defined: adds `perf_cycles`.
  - It clears on accepted `start`, increments every cycle while `busy`, and freezes at `done`.
  - On abort it holds its value.
- PE_CTRL_PERF_EN undefined: the port and counter are absent, and there is no other behavioural difference.

## Test plan
All scenarios use PE_NUM=2, LOAD_NUM=4, COMP_CYCLES=5, DRAIN_CYCLES=2.
- Nominal run: `start`, then 8 contiguous beats 0x1..0x8 → `arr_din_v` high for 8 cycles carrying 0x1..0x8. `pe_sel`=0 for beats 1–4 and 1 for beats 5–8. `arr_load` is high 6–7 cycles after the last beat (2 cycles), `m_valid` is 1 cycle later, and `done` pulses once.
- Late stream: `start`, `s_valid` held low for 3 cycles, then 8 beats → no `err`, and the run completes as in the nominal case.
- Gap: `start`, 3 beats, `s_valid=0` for 1 cycle → `err=1` and IDLE next cycle, no `arr_load`, no `done`. A new `start` clears `err`.
- Abort in COMPUTE at cycle 2 → IDLE next cycle, `arr_load` never asserts, `busy=0`. Repeat with `start`+`abort` together in IDLE → the block stays IDLE.
- Async reset asserted during DRAIN → `arr_load`, `m_valid`, and `busy` are 0 immediately. After reset, a full nominal run passes.
- PE_CTRL_PERF_EN: nominal run → `perf_cycles` equals the `busy` high count (1+8+5+2+1=17). `start` ignored while `busy` leaves `perf_cycles` uncleared.
